// File: rtl/and_pair_monitor.sv
// and_pair_monitor: samples the paired AND results, counts rising edges of
// each channel and of their conjunction, and exports the counts through a
// four-phase snapshot handshake (snap_req / snap_ack).
// Build option: define AND_PAIR_MON_SAT_EN to make the live counters saturate
// at all-ones instead of wrapping.
module and_pair_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       res,
  input  logic             clear,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic [CNT_W-1:0] cnt_hi,
  output logic [CNT_W-1:0] cnt_lo,
  output logic [CNT_W-1:0] cnt_both
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Channel index map for the event arrays: 0 = lower pair, 1 = upper pair,
  // 2 = both pairs high together.
  localparam int N_CH = 3;

  logic [1:0]       r_s0;
  logic [1:0]       r_s1;
  logic [N_CH-1:0]  w_rise;
  logic [CNT_W-1:0] w_live [N_CH];
  state_t           r_state;
  state_t           w_state_next;
  logic             w_capture;

  // Two-stage sample of res; s1 is the previous sample used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 2'b00;
      r_s1 <= 2'b00;
    end else begin
      r_s0 <= res;
      r_s1 <= r_s0;
    end
  end

  // The conjunction edge is detected on its own, so a single sample can raise
  // several rise terms at once.
  always_comb begin
    w_rise    = '0;
    w_rise[0] = r_s0[0] & ~r_s1[0];
    w_rise[1] = r_s0[1] & ~r_s1[1];
    w_rise[2] = (r_s0[1] & r_s0[0]) & ~(r_s1[1] & r_s1[0]);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_live;

      // Live counter: clear beats a coincident increment, so that event is lost.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          r_live <= '0;
        end else if (w_rise[gi]) begin
`ifdef AND_PAIR_MON_SAT_EN
          if (r_live != {CNT_W{1'b1}}) begin
            r_live <= r_live + CNT_W'(1);
          end
`else
          r_live <= r_live + CNT_W'(1);
`endif
        end
      end

      assign w_live[gi] = r_live;
    end
  endgenerate

  // Handshake state register; reset abandons any handshake in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and acknowledge decode; DONE forces one dead cycle between captures.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    snap_ack     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (snap_req) begin
          w_capture    = 1'b1;
          w_state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        snap_ack = 1'b1;
        if (!snap_req) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Snapshot registers load only on IDLE->ACK and see the pre-increment count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo   <= '0;
      cnt_hi   <= '0;
      cnt_both <= '0;
    end else if (w_capture) begin
      cnt_lo   <= w_live[0];
      cnt_hi   <= w_live[1];
      cnt_both <= w_live[2];
    end
  end

endmodule

// File: tb/tb_and_pair_monitor.sv
// Bench for and_pair_monitor: two instances (CNT_W=8 and CNT_W=2) share the
// stimulus. An event-list model predicts snap_ack and the snapshot outputs,
// checked every falling edge; directed literal checks pin the model.
module tb_and_pair_monitor;

  localparam int W8 = 8;
  localparam int W2 = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    res;
  logic          clear;
  logic          snap_req;
  logic          ack8, ack2;
  logic [W8-1:0] hi8, lo8, both8;
  logic [W2-1:0] hi2, lo2, both2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  and_pair_monitor #(.CNT_W(W8)) u_dut8 (
    .clk(clk), .rst(rst), .res(res), .clear(clear), .snap_req(snap_req),
    .snap_ack(ack8), .cnt_hi(hi8), .cnt_lo(lo8), .cnt_both(both8)
  );

  and_pair_monitor #(.CNT_W(W2)) u_dut2 (
    .clk(clk), .rst(rst), .res(res), .clear(clear), .snap_req(snap_req),
    .snap_ack(ack2), .cnt_hi(hi2), .cnt_lo(lo2), .cnt_both(both2)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- model ----------------
  // Each detected edge is recorded with the clock edge at which it becomes
  // visible in the live count. A capture at edge c reports every recorded
  // edge credited after the most recent clear/reset and no later than c-1.
  int q_hi[$];
  int q_lo[$];
  int q_both[$];
  int edge_n    = 0;
  int last_zero = 0;
  logic [1:0] m_prev = 2'b00;
  int m_phase = 0;   // 0 idle, 1 acknowledging, 2 dead cycle
  int m_snap_hi = 0, m_snap_lo = 0, m_snap_both = 0;

  function automatic int count_in(input int q[$], input int lo_excl, input int hi_incl);
    int n = 0;
    foreach (q[k]) if (q[k] > lo_excl && q[k] <= hi_incl) n++;
    return n;
  endfunction

  function automatic int conv(input int n, input int w);
    int mx = (1 << w) - 1;
`ifdef AND_PAIR_MON_SAT_EN
    return (n > mx) ? mx : n;
`else
    return n & mx;
`endif
  endfunction

  always @(posedge clk) begin
    logic [1:0] cur;
    edge_n++;
    if (rst) begin
      last_zero   = edge_n;
      m_prev      = 2'b00;
      m_phase     = 0;
      m_snap_hi   = 0;
      m_snap_lo   = 0;
      m_snap_both = 0;
    end else begin
      if (m_phase == 0 && snap_req) begin
        m_snap_hi   = count_in(q_hi,   last_zero, edge_n - 1);
        m_snap_lo   = count_in(q_lo,   last_zero, edge_n - 1);
        m_snap_both = count_in(q_both, last_zero, edge_n - 1);
        m_phase     = 1;
      end else if (m_phase == 1 && !snap_req) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      if (clear) last_zero = edge_n;
      cur = res;
      if (cur[1] && !m_prev[1]) q_hi.push_back(edge_n + 1);
      if (cur[0] && !m_prev[0]) q_lo.push_back(edge_n + 1);
      if ((&cur) && !(&m_prev)) q_both.push_back(edge_n + 1);
      m_prev = cur;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ack8",  int'(ack8),  (m_phase == 1) ? 1 : 0);
    check("hi8",   int'(hi8),   conv(m_snap_hi,   W8));
    check("lo8",   int'(lo8),   conv(m_snap_lo,   W8));
    check("both8", int'(both8), conv(m_snap_both, W8));
    check("ack2",  int'(ack2),  (m_phase == 1) ? 1 : 0);
    check("hi2",   int'(hi2),   conv(m_snap_hi,   W2));
    check("lo2",   int'(lo2),   conv(m_snap_lo,   W2));
    check("both2", int'(both2), conv(m_snap_both, W2));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One minimal handshake with literal expectations on the 8-bit instance.
  task automatic snap(input string nm, input int e_hi, input int e_lo, input int e_both);
    snap_req = 1'b1;
    cyc(1);
    check({nm, "_ack"},  int'(ack8),  1);
    check({nm, "_hi"},   int'(hi8),   e_hi);
    check({nm, "_lo"},   int'(lo8),   e_lo);
    check({nm, "_both"}, int'(both8), e_both);
    snap_req = 1'b0;
    cyc(1);
    check({nm, "_done_ack"}, int'(ack8), 0);
    cyc(1);
  endtask

  function automatic logic [1:0] and_pair(input logic [3:0] a);
    return {a[3] & a[2], a[1] & a[0]};
  endfunction

  initial begin
    logic [3:0] seq [5];
    seq[0] = 4'b0000; seq[1] = 4'b0011; seq[2] = 4'b1100;
    seq[3] = 4'b0000; seq[4] = 4'b1111;

    // Reset held with both results high: outputs zero, then one edge each.
    rst = 1'b1; res = 2'b11; clear = 1'b0; snap_req = 1'b0;
    cyc(2);
    check("rst_ack", int'(ack8), 0);
    check("rst_hi",  int'(hi8),  0);
    rst = 1'b0;
    cyc(2);
    snap("post_rst", 1, 1, 1);

    // Stimulus sequence through the AND pair after a clean clear.
    res = 2'b00;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res = and_pair(seq[i]);
      cyc(2);
    end

    // Long handshake: ack held for 4 cycles, res[0] toggling does not move cnt_lo.
    snap_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("hs_ack",  int'(ack8),  1);
      check("hs_hi",   int'(hi8),   2);
      check("hs_lo",   int'(lo8),   2);
      check("hs_both", int'(both8), 1);
      res[0] = ~res[0];
    end
    snap_req = 1'b0;
    cyc(1);
    check("hs_done_ack", int'(ack8), 0);
    cyc(1);
    check("hs_idle_ack", int'(ack8), 0);

    // Clear coincides with the edge at which a res[1] rise would be counted.
    res = 2'b00;
    cyc(2);
    res = 2'b10;
    cyc(1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(2);
    snap("clr_rise", 0, 0, 0);
    res = 2'b00;
    cyc(2);
    res = 2'b10;
    cyc(2);
    snap("after_clr", 1, 0, 0);

    // Overflow: five rises on res[0], observed on both counter widths.
    res = 2'b00;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res = 2'b01;
      cyc(1);
      res = 2'b00;
      cyc(1);
    end
    cyc(2);
    snap_req = 1'b1;
    cyc(1);
`ifdef AND_PAIR_MON_SAT_EN
    check("ovf_lo2", int'(lo2), 3);
`else
    check("ovf_lo2", int'(lo2), 1);
`endif
    check("ovf_lo8", int'(lo8), 5);
    snap_req = 1'b0;
    cyc(2);

    // Reset during ACK abandons the handshake; a held request recaptures.
    res = 2'b11;
    cyc(3);
    snap_req = 1'b1;
    cyc(1);
    check("mid_ack_before", int'(ack8), 1);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_ack", int'(ack8), 0);
    check("mid_rst_lo",  int'(lo8),  0);
    rst = 1'b0;
    cyc(1);
    check("mid_recap_ack", int'(ack8), 1);
    check("mid_recap_hi",  int'(hi8),  0);
    snap_req = 1'b0;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
